// File: rtl/ace_ccu_snoop_req_buf.sv
// ace_ccu_snoop_req_buf
// Round-robin arbiter that funnels NumInp AC snoop requests onto one AC
// output. Each issued snoop leaves a {sel, idx} record in a small control
// FIFO for the response-collect logic. The number of snoops in flight is
// capped at MaxTrans by a counter that snoop_done_i decrements.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ac_valids_i/_readies_o per-input snoop handshake (readies one-hot0)
//   ac_chans_i, ac_sel_i  per-input payload and target select vector
//   ac_valid_o/ready_i    arbitrated snoop handshake, ac_chan_o payload
//   ctrl_valid_o/ready_i  control FIFO head handshake, ctrl_o = {sel, idx}
//   snoop_done_i          one-cycle pulse per fully retired snoop
//   outstanding_o         current number of snoops in flight
module ace_ccu_snoop_req_buf #(
  parameter int unsigned NumInp    = 2,
  parameter int unsigned NumOup    = 2,
  parameter type         ac_chan_t = logic,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned CtrlDepth = 4,
  localparam int unsigned IdxW  = (NumInp > 1) ? $clog2(NumInp) : 1,
  localparam int unsigned CntW  = $clog2(MaxTrans + 1),
  localparam int unsigned CtrlW = NumOup + IdxW
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumInp-1:0]              ac_valids_i,
  output logic [NumInp-1:0]              ac_readies_o,
  input  ac_chan_t [NumInp-1:0]          ac_chans_i,
  input  logic [NumInp-1:0][NumOup-1:0]  ac_sel_i,
  output logic                           ac_valid_o,
  input  logic                           ac_ready_i,
  output ac_chan_t                       ac_chan_o,
  output logic                           ctrl_valid_o,
  input  logic                           ctrl_ready_i,
  output logic [CtrlW-1:0]               ctrl_o,
  input  logic                           snoop_done_i,
  output logic [CntW-1:0]                outstanding_o
);

  localparam int unsigned PtrW  = (CtrlDepth > 1) ? $clog2(CtrlDepth) : 1;
  localparam int unsigned FcntW = $clog2(CtrlDepth + 1);

  typedef struct packed {
    logic [NumOup-1:0] sel;
    logic [IdxW-1:0]   idx;
  } ctrl_t;

  logic [IdxW-1:0]  rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [IdxW-1:0]  lock_idx_q, lock_idx_d;
  logic [CntW-1:0]  out_q, out_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  ctrl_t            mem_q [CtrlDepth];

  logic [IdxW-1:0]  cand;
  logic [IdxW-1:0]  arb_idx, gnt_idx;
  logic             arb_found, arb_valid;
  logic             can_issue, fifo_full, accept, push, pop;
  ctrl_t            push_rec;

  // Search upward from the round-robin pointer, wrapping at NumInp.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NumInp); k++) begin
      cand = IdxW'((int'(rr_q) + k) % int'(NumInp));
      if (!arb_found && ac_valids_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A presented-but-unaccepted grant is frozen so payload and record stay put.
  assign gnt_idx   = lock_q ? lock_idx_q : arb_idx;
  assign arb_valid = lock_q | arb_found;
  assign fifo_full = (fcnt_q == FcntW'(CtrlDepth));
  assign can_issue = (out_q < CntW'(MaxTrans)) && !fifo_full;
  // Gated by reset so no handshake can complete in a reset cycle.
  assign ac_valid_o = arb_valid && can_issue && !rst_i;
  assign ac_chan_o  = ac_chans_i[gnt_idx];
  assign accept     = ac_valid_o && ac_ready_i;

  for (genvar gi = 0; gi < NumInp; gi++) begin : g_ready
    assign ac_readies_o[gi] = accept && (gnt_idx == IdxW'(gi));
  end

  assign push_rec.sel = ac_sel_i[gnt_idx];
  assign push_rec.idx = gnt_idx;
  assign push         = accept;
  assign pop          = ctrl_valid_o && ctrl_ready_i;
  assign ctrl_valid_o = (fcnt_q != '0);
  assign ctrl_o       = mem_q[rd_ptr_q];
  assign outstanding_o = out_q;

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    out_d      = out_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q;

    if (accept) begin
      rr_d   = (gnt_idx == IdxW'(NumInp - 1)) ? '0 : gnt_idx + IdxW'(1);
      lock_d = 1'b0;
    end else if (ac_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end

    // A done with nothing outstanding is illegal; it is ignored (saturate).
    unique case ({accept, snoop_done_i})
      2'b10:   out_d = out_q + CntW'(1);
      2'b01:   if (out_q != '0) out_d = out_q - CntW'(1);
      default: out_d = out_q;
    endcase

    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(CtrlDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(CtrlDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + FcntW'(1);
      2'b01:   fcnt_d = fcnt_q - FcntW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      out_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      out_q      <= out_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

`ifndef SYNTHESIS
  a_readies_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(ac_readies_o));
  a_chan_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (ac_valid_o && !ac_ready_i) |=> (ac_valid_o && $stable(ac_chan_o)));
  a_out_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    out_q <= CntW'(MaxTrans));
  a_no_withdraw: assert property (@(posedge clk_i) disable iff (rst_i)
    lock_q |-> ac_valids_i[lock_idx_q]);
  a_done_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    snoop_done_i |-> (out_q != '0));
`endif

endmodule
